// File: rtl/inv_sub_bytes_engine_pkg.sv
// Shared types and GF((2^4)^2) helpers for the inverse SubBytes engine.
// GF(2^4) is built as GF((2^2)^2) with phi = {10}; GF(2^8) uses lambda = {1100}.
package inv_sub_bytes_engine_pkg;

  localparam int STATE_W = 128;
  localparam int NUM_BYTES = 16;
  localparam logic [7:0] AFFINE_C = 8'h63;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic [1:0] gf4_mul(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
            (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] mul_phi(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [3:0] gf16_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [1:0] hh;
    hh = gf4_mul(a[3:2], b[3:2]);
    return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
            mul_phi(hh) ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    logic [1:0] h2;
    h2 = gf4_sq(a[3:2]);
    return {h2, mul_phi(h2) ^ gf4_sq(a[1:0])};
  endfunction

  // In GF(4) the inverse equals the square, and 0 stays 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] d;
    logic [1:0] di;
    d = mul_phi(gf4_sq(a[3:2])) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
    di = gf4_sq(d);
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction

  function automatic logic [3:0] mul_lambda(input logic [3:0] a);
    return gf16_mul(a, 4'hC);
  endfunction

  function automatic logic [7:0] iso_map(input logic [7:0] x);
    return {x[7] ^ x[5],
            x[7] ^ x[6] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
            x[7] ^ x[5] ^ x[3] ^ x[2],
            x[7] ^ x[5] ^ x[3] ^ x[2] ^ x[1],
            x[7] ^ x[6] ^ x[2] ^ x[1],
            x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
            x[6] ^ x[4] ^ x[1],
            x[6] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [7:0] inv_iso_map(input logic [7:0] x);
    return {x[7] ^ x[6] ^ x[5] ^ x[1],
            x[6] ^ x[2],
            x[6] ^ x[5] ^ x[1],
            x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[1],
            x[5] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
            x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
            x[5] ^ x[4],
            x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[0]};
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    logic [7:0] x;
    x = a ^ AFFINE_C;
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
  endfunction

endpackage

// File: rtl/inv_sub_bytes_engine_sub_byte.sv
// One inverse S-box lane: inverse affine, then composite-field inversion.
// Zero passes through inversion as zero.
module inv_sub_byte_comb
  import inv_sub_bytes_engine_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] t;
  logic [3:0] ah;
  logic [3:0] al;
  logic [3:0] d;
  logic [3:0] di;
  logic [3:0] rh;
  logic [3:0] rl;

  always_comb begin
    t = iso_map(inv_affine(in_byte));
    ah = t[7:4];
    al = t[3:0];
    d = mul_lambda(gf16_sq(ah)) ^ gf16_mul(ah, al) ^ gf16_sq(al);
    di = gf16_inv(d);
    rh = gf16_mul(ah, di);
    rl = gf16_mul(ah ^ al, di);
    out_byte = inv_iso_map({rh, rl});
  end

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Iterative InvSubBytes over a 128-bit AES state, BYTES_PER_CYCLE lanes.
// Handshake: accept in IDLE, present in DONE until out_ready.
module inv_sub_bytes_engine
  import inv_sub_bytes_engine_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int B = BYTES_PER_CYCLE;
  localparam int NG = NUM_BYTES / B;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NG - 1);

  state_e state;
  state_e state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [STATE_W-1:0] work;
  logic [STATE_W-1:0] work_nxt;
  logic [STATE_W-1:0] work_sub;
  logic [7:0] lane_in [B];
  logic [7:0] lane_out [B];

  always_comb begin
    for (int l = 0; l < B; l++) begin
      lane_in[l] = work[8*(int'(cnt)*B + l) +: 8];
    end
  end

  for (genvar l = 0; l < B; l++) begin : g_lane
    inv_sub_byte_comb u_lane (
      .in_byte  (lane_in[l]),
      .out_byte (lane_out[l])
    );
  end

  always_comb begin
    work_sub = work;
    for (int l = 0; l < B; l++) begin
      work_sub[8*(int'(cnt)*B + l) +: 8] = lane_out[l];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    work_nxt = work;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          work_nxt = in_state;
          cnt_nxt = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        work_nxt = work_sub;
        if (cnt == LAST) begin
          cnt_nxt = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      work <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      work <= work_nxt;
    end
  end

  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy = (state == BUSY);
  assign out_state = work;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Scoreboard bench for inv_sub_bytes_engine (B=4 main, B=1/B=16 latency).
// Expected bytes come from the standard AES inverse S-box table.
module tb_inv_sub_bytes_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic in_ready;
  logic out_valid;
  logic busy;
  logic [127:0] out_state;

  logic x_valid = 1'b0;
  logic x_ready = 1'b0;
  logic [127:0] x_state = '0;
  logic r1, v1, b1, r16, v16, b16;
  logic [127:0] s1, s16;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  bit b2b = 1'b0;
  bit have_prev = 1'b0;
  logic [127:0] q [$];

  logic [7:0] isb [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  localparam logic [127:0] MIXED = {{10{8'h63}}, 48'hED16F2637C00};
  localparam logic [127:0] MIXED_EXP = {80'h0, 48'h53FF04000152};

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_valid), .in_ready(r1), .in_state(x_state),
    .out_valid(v1), .out_ready(x_ready), .out_state(s1),
    .busy(b1)
  );

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_valid), .in_ready(r16), .in_state(x_state),
    .out_valid(v16), .out_ready(x_ready), .out_state(s16),
    .busy(b16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] model(input logic [127:0] blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = isb[blk[8*k +: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_pop: unexpected output %0h with empty queue", out_state);
      end else begin
        check("sb_data", out_state, q.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] blk, input logic [127:0] exp);
    int k;
    in_valid = 1'b1;
    in_state = blk;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept", {127'd0, in_ready}, 128'd1);
    if (!in_ready) return;
    q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (b2b && have_prev) check("throughput", acc_cyc - prev_acc, 6);
    have_prev = 1'b1;
    prev_acc = acc_cyc;
  endtask

  task automatic lat_main(input string name, input logic [127:0] blk);
    int lat;
    bit rdy_low;
    out_ready = 1'b0;
    send(blk, model(blk));
    in_valid = 1'b0;
    lat = -1;
    rdy_low = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) rdy_low = 1'b0;
    end
    check({name, "_lat"}, lat, 4);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    if (in_ready) rdy_low = 1'b0;
    check({name, "_rdy_low"}, rdy_low, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic lat_x(input bit sel, input int exp_lat);
    int lat;
    bit rdy_low;
    x_ready = 1'b0;
    x_state = MIXED;
    x_valid = 1'b1;
    @(negedge clk);
    check("x_idle", sel ? r16 : r1, 1);
    @(posedge clk);
    #1 x_valid = 1'b0;
    lat = -1;
    rdy_low = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sel ? v16 : v1) begin
        lat = k;
        break;
      end
      if (sel ? r16 : r1) rdy_low = 1'b0;
    end
    check(sel ? "lat_b16" : "lat_b1", lat, exp_lat);
    check(sel ? "data_b16" : "data_b1", sel ? s16 : s1, MIXED_EXP);
    @(posedge clk);
    #1 x_ready = 1'b1;
    @(negedge clk);
    if (sel ? r16 : r1) rdy_low = 1'b0;
    check(sel ? "rdy_low_b16" : "rdy_low_b1", rdy_low, 1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] bp_blk;
    logic [127:0] bp_exp;
    bit no_valid;
    int k;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_state", out_state, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(MIXED, MIXED_EXP);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    lat_main("b4", MIXED);

    for (int i = 0; i < 16; i++) bp_blk[8*i +: 8] = 8'(i * 17);
    bp_exp = model(bp_blk);
    out_ready = 1'b0;
    send(bp_blk, bp_exp);
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_state = {4{$urandom()}};
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_state", out_state, bp_exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    send({16{8'h52}}, model({16{8'h52}}));
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_in_ready", in_ready, 1);
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_out_state", out_state, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    no_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) no_valid = 1'b0;
    end
    check("mid_no_valid", no_valid, 1);
    @(posedge clk);
    #1;
    lat_main("post_rst", {16{8'h63}});

    out_ready = 1'b1;
    b2b = 1'b1;
    have_prev = 1'b0;
    for (int v = 0; v < 256; v++) begin
      send({16{8'(v)}}, {16{isb[v]}});
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    lat_x(1'b0, 16);
    lat_x(1'b1, 1);

    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("sb_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_engine.md
INV_SUB_BYTES_ENGINE -- requirements
Module: inv_sub_bytes_engine

Interface
REQ-001 Parameter: BYTES_PER_CYCLE, default 4, inverse S-box lanes used per cycle; legal values 1, 2, 4, 8, 16 only.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_state holds a block to be inverse-substituted.
REQ-005 in_ready  output  1  engine can accept a block.
REQ-006 in_state  input  128  AES state; byte k = bits [8k+7:8k].
REQ-007 out_valid  output  1  out_state holds a completed result.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 out_state  output  128  InvSubBytes(in_state), with the same byte ordering as in_state.
REQ-010 busy  output  1  engine is in state BUSY.

Function
REQ-011 States SHALL be IDLE, BUSY and DONE; the reset state is IDLE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Acceptance SHALL occur when in_valid=1 and in_ready=1 at a rising edge: latch in_state into the working register, clear the group counter, go to BUSY.
REQ-014 In BUSY, each cycle SHALL replace bytes [g*B .. g*B+B-1] with InvSbox(byte), where B=BYTES_PER_CYCLE and g=group counter; the counter SHALL then increment.
REQ-015 Counter width SHALL be clog2(16/B), with a minimum of 1 bit. When g=16/B-1 the engine SHALL go to DONE and the counter SHALL wrap to 0.
REQ-016 Latency: out_valid SHALL rise exactly 16/B cycles after the acceptance edge (4 cycles at the default).
REQ-017 In DONE, out_state and out_valid SHALL hold stable until out_ready=1 at an edge, then the engine SHALL go to IDLE.
REQ-018 The IDLE-to-BUSY transition SHALL NOT occur in the same cycle as the DONE handshake; throughput is one block per 16/B+2 cycles minimum.
REQ-019 in_valid and in_state SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-020 out_state SHALL be driven directly from the working register; its value outside DONE is don't-care for checking.
REQ-021 InvSbox SHALL be computed in logic, not a lookup table: inverse affine transform, isomorphic map to GF((2^4)^2), composite-field multiplicative inverse, then inverse isomorphic map. 0x00 SHALL map through inversion to 0x00.
REQ-022 There SHALL be no combinational path from in_valid or out_ready to any output.

Reset
REQ-023 When rst_n=0, regardless of clk: state=IDLE, counter=0, working register=0, in_ready=1, out_valid=0, busy=0, out_state=0.
REQ-024 A reset asserted in BUSY or DONE SHALL discard the block in flight; no out_valid pulse follows.
REQ-025 Reset deassertion SHALL be consumed synchronously by the flops; the first acceptance is possible at the first edge after rst_n rises.

Structure
REQ-026 The shared package SHALL hold the state enum (IDLE, BUSY, DONE), the 128-bit state width, the byte count 16, the affine constant 8'h63, and the GF helper functions: iso map, inverse iso map, GF(2^4) multiply/square/inverse, lambda and phi constant multiplies.
REQ-027 There SHALL be one combinational sub-module, inv_sub_byte_comb (8-bit in, 8-bit out), instantiated BYTES_PER_CYCLE times; lane selection SHALL be a mux on the group counter.
REQ-028 The estimated RTL size is 120-400 lines including the sub-module.

Verification
REQ-029 Exhaustive: every byte value 0x00-0xFF replicated across all 16 bytes -> out_state = InvSbox per byte. Sample checks: 0x63->0x00, 0x7C->0x01, 0x00->0x52, 0x16->0xFF, 0xF2->0x04, 0xED->0x53.
REQ-030 Mixed block in_state=0x...ED16F2637C00 (remaining upper bytes 0x63) -> byte 0=0x52, 1=0x01, 2=0x00, 3=0x04, 4=0xFF, 5=0x53, all other bytes 0x00.
REQ-031 Latency: for each B in {1, 4, 16}, accept at edge T -> out_valid first high at edge T+16/B; in_ready low from T through the DONE handshake.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state and out_valid stable; toggle in_valid and in_state meanwhile -> no effect.
REQ-033 Reset mid-operation: assert rst_n=0 at the second BUSY cycle -> all outputs at reset values immediately; after release, a new block of 0x63 bytes yields all 0x00 with normal latency.
REQ-034 Back-to-back: in_valid held high with out_ready=1 -> blocks accepted every 16/B+2 cycles, and results appear in order.
